// File: rtl/apb_master_bridge.sv
// APB requester: turns a valid/ready command stream into APB transfers and returns
// one response per command; a watchdog aborts transfers whose completer never responds.
//   state  | meaning
//   IDLE   | bus idle, cmd_ready high, waiting for a command
//   SETUP  | psel=1, penable=0 for one cycle
//   ACCESS | psel=1, penable=1 until pready or watchdog abort
module apb_master_bridge #(
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_strb,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_W-1:0]     paddr,
  output logic [DATA_W/8-1:0]   pstrb,
  output logic [DATA_W-1:0]     pwdata,
  input  logic                  pready,
  input  logic                  pslverr,
  input  logic [DATA_W-1:0]     prdata
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_accept;
  logic                w_done;
  logic                w_timeout;
  logic                w_cmd_ready;
  logic                w_psel;
  logic                w_penable;
  logic [CNT_W-1:0]    r_wait_cnt;
  logic                r_pwrite;
  logic [ADDR_W-1:0]   r_paddr;
  logic [STRB_W-1:0]   r_pstrb;
  logic [DATA_W-1:0]   r_pwdata;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;
  logic                r_rsp_timeout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_SETUP;
      S_SETUP:  w_next = S_ACCESS;
      S_ACCESS: if (w_done || w_timeout) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Bus strobes are decoded straight from the state flops, so reset clears them at once.
  always_comb begin
    w_cmd_ready = (r_state == S_IDLE) && !reset;
    w_accept    = w_cmd_ready && cmd_valid;
    w_psel      = (r_state != S_IDLE);
    w_penable   = (r_state == S_ACCESS);
    w_done      = (r_state == S_ACCESS) && pready;
    w_timeout   = (TIMEOUT_CYCLES != 0) && (r_state == S_ACCESS) && !pready &&
                  (r_wait_cnt == CNT_LIMIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_SETUP) begin
      r_wait_cnt <= '0;
    end else if ((r_state == S_ACCESS) && !pready && (r_wait_cnt != CNT_MAX)) begin
      r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end
  end

  // Reads drive zero strobes and data; values persist through IDLE to avoid bus toggling.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
      r_pstrb  <= '0;
      r_pwdata <= '0;
    end else if (w_accept) begin
      r_pwrite <= cmd_write;
      r_paddr  <= cmd_addr;
      r_pstrb  <= cmd_write ? cmd_strb : '0;
      r_pwdata <= cmd_write ? cmd_wdata : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_rsp_valid <= w_done || w_timeout;
      if (w_done) begin
        r_rsp_rdata   <= r_pwrite ? '0 : prdata;
        r_rsp_err     <= pslverr;
        r_rsp_timeout <= 1'b0;
      end else if (w_timeout) begin
        r_rsp_rdata   <= '0;
        r_rsp_err     <= 1'b1;
        r_rsp_timeout <= 1'b1;
      end
    end
  end

  assign cmd_ready   = w_cmd_ready;
  assign psel        = w_psel;
  assign penable     = w_penable;
  assign pwrite      = r_pwrite;
  assign paddr       = r_paddr;
  assign pstrb       = r_pstrb;
  assign pwdata      = r_pwdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed vector table, hand sequences for
// throughput and mid-transfer reset, then randomized transfers against a response model.
module tb_apb_master_bridge;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [3:0]  pstrb;
  logic [31:0] pwdata;
  logic        pready, pslverr;
  logic [31:0] prdata;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  apb_master_bridge #(.ADDR_W(12), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pstrb(pstrb),
    .pwdata(pwdata), .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;     // pready-low ACCESS cycles before pready rises
    logic [31:0] prdata;
    logic        slverr;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Response rules: abort once the completer stalls TO cycles, else pass status through.
  function automatic vec_t ref_model(input vec_t v);
    vec_t r;
    r           = v;
    r.exp_to    = (v.waits >= TO);
    r.exp_err   = r.exp_to || v.slverr;
    r.exp_rdata = (r.exp_to || v.wr) ? 32'h0 : v.prdata;
    return r;
  endfunction

  // Called just after a falling edge; returns on the falling edge that shows rsp_valid.
  task automatic run_txn(input vec_t v, output int t_acc);
    int          k, pen_cnt, lat, exp_lat, exp_pen;
    logic        bad, got;
    logic [3:0]  e_strb;
    logic [31:0] e_wd;
    e_strb    = v.wr ? v.strb : 4'h0;
    e_wd      = v.wr ? v.wdata : 32'h0;
    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    cmd_strb  = v.strb;
    k = 0;
    while (!cmd_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    t_acc = cyc;
    if (!cmd_ready) begin
      chk("accept_wait", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom_range(0, 1));
    cmd_addr  = 12'($urandom);
    cmd_wdata = $urandom;
    cmd_strb  = 4'($urandom);
    chk("setup_psel", 32'(psel), 32'd1);
    chk("setup_penable", 32'(penable), 32'd0);
    chk("setup_paddr", 32'(paddr), 32'(v.addr));
    chk("setup_pwrite", 32'(pwrite), 32'(v.wr));
    chk("setup_pstrb", 32'(pstrb), 32'(e_strb));
    chk("setup_pwdata", pwdata, e_wd);
    chk("setup_no_rsp", 32'(rsp_valid), 32'd0);
    pready  = 1'($urandom_range(0, 1));
    prdata  = $urandom;
    pslverr = 1'($urandom_range(0, 1));
    k = 0; pen_cnt = 0; bad = 1'b0; got = 1'b0;
    for (int g = 0; g < 40; g++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
      if (!(psel && penable)) bad = 1'b1;
      if (paddr !== v.addr || pwrite !== v.wr || pstrb !== e_strb || pwdata !== e_wd) bad = 1'b1;
      pen_cnt++;
      pready  = (k == v.waits);
      prdata  = (k == v.waits) ? v.prdata : $urandom;
      pslverr = (k == v.waits) ? v.slverr : 1'($urandom_range(0, 1));
      k++;
    end
    pready  = 1'b0;
    pslverr = 1'b0;
    if (!got) begin
      chk("rsp_arrival", 32'd0, 32'd1);
      return;
    end
    lat     = cyc - t_acc;
    exp_lat = 3 + ((v.waits < TO - 1) ? v.waits : TO - 1);
    exp_pen = (v.waits < TO) ? v.waits + 1 : TO;
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("penable_cycles", 32'(pen_cnt), 32'(exp_pen));
    chk("access_stable", 32'(bad), 32'd0);
    chk("rsp_rdata", rsp_rdata, v.exp_rdata);
    chk("rsp_err", 32'(rsp_err), 32'(v.exp_err));
    chk("rsp_timeout", 32'(rsp_timeout), 32'(v.exp_to));
    chk("idle_psel", 32'({psel, penable}), 32'd0);
    chk("rsp_cmd_ready", 32'(cmd_ready), 32'd1);
  endtask

  vec_t tbl[5];
  int   t_prev, t_now;

  initial begin
    vec_t v;
    logic seen;
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_strb = '0; pready = 1'b0; pslverr = 1'b0; prdata = '0;

    tbl[0] = '{1'b1, 12'h000, 32'hA5A5_5A5A, 4'hF, 0,  32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0, 1'b0};
    tbl[1] = '{1'b0, 12'h004, 32'hFFFF_FFFF, 4'hF, 3,  32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 12'h008, 32'h0000_0001, 4'h3, 1,  32'h5555_AAAA, 1'b1, 32'h0,         1'b1, 1'b0};
    tbl[3] = '{1'b0, 12'h00C, 32'h0,         4'h0, 16, 32'hCAFE_F00D, 1'b0, 32'h0,         1'b1, 1'b1};
    tbl[4] = '{1'b0, 12'h010, 32'h0,         4'h0, 15, 32'h0BAD_C0DE, 1'b1, 32'h0BAD_C0DE, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_pwrite", 32'(pwrite), 32'd0);
    chk("rst_paddr", 32'(paddr), 32'd0);
    chk("rst_pstrb", 32'(pstrb), 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'({rsp_err, rsp_timeout}), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 5; i++) run_txn(tbl[i], t_now);

    // Back-to-back zero-wait writes: one accept every 3 cycles.
    v = '{1'b1, 12'h100, 32'h0, 4'hF, 0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      v.addr  = 12'h100 + 12'(4 * i);
      v.wdata = 32'h1111_0000 + 32'(i);
      run_txn(ref_model(v), t_now);
      if (i > 0) chk("b2b_spacing", 32'(t_now - t_prev), 32'd3);
      t_prev = t_now;
    end

    // Reset in the middle of ACCESS.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h020; cmd_strb = 4'h0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    pready = 1'b0;
    chk("pre_rst_penable", 32'(penable), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_bus", 32'({psel, penable}), 32'd0);
    chk("async_rst_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid || psel) seen = 1'b1;
    end
    chk("no_rsp_after_rst", 32'(seen), 32'd0);
    v = '{1'b0, 12'h024, 32'h0, 4'h0, 2, 32'h7777_1234, 1'b0, 32'h0, 1'b0, 1'b0};
    run_txn(ref_model(v), t_now);

    // Randomized transfers, including the watchdog boundary.
    for (int i = 0; i < 40; i++) begin
      int r;
      r        = $urandom_range(0, 9);
      v.wr     = 1'($urandom_range(0, 1));
      v.addr   = 12'($urandom);
      v.wdata  = $urandom;
      v.strb   = 4'($urandom);
      v.waits  = (r < 6) ? r : (r == 6) ? 14 : (r == 7) ? 15 : (r == 8) ? 16 : 20;
      v.prdata = $urandom;
      v.slverr = 1'($urandom_range(0, 1));
      run_txn(ref_model(v), t_now);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
